// File: rtl/x3q16_pkg.sv
// Shared types and constants for the x3q16 memory controller.
// Holds the FSM encoding, the bus widths and the default halt address.
package x3q16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  localparam logic [ADDR_W-1:0] HALT_ADDR_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DONE = 3'd2,
    ST_WR      = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/x3q16_mem_ctrl.sv
// CPU-to-SRAM bridge: accepts one read or write per request, drives the SRAM,
// returns read data / completion pulses and flags a read of the halt address.
import x3q16_pkg::*;

module x3q16_mem_ctrl #(
  parameter int                READ_LAT  = 1,
  parameter logic [ADDR_W-1:0] HALT_ADDR = HALT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              request,
  input  logic              request_type,
  input  logic [ADDR_W-1:0] request_address,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] memory_in,
  output logic              memory_ready,
  output logic              write_complete,
  output logic              memory_critical,
  output logic              halted,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output state_t            dbg_state
);

  // Handshake: request is a level held by the CPU until it sees memory_ready
  // or write_complete; it is only sampled in IDLE, and HOLD waits for it to
  // drop so a held request is never serviced twice.

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_latch;
  logic                w_rd_start;
  logic                w_capture;
  logic                w_rdy_nxt;
  logic                w_wr_fire;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_memory_in;
  logic                r_memory_ready;
  logic                r_write_complete;
  logic                r_halted;
  logic                r_sram_en;
  logic                r_sram_we;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_sram_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_rd_start  = 1'b0;
    w_capture   = 1'b0;
    w_rdy_nxt   = 1'b0;
    w_wr_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (request) begin
          w_latch = 1'b1;
          if (request_type) begin
            w_state_nxt = ST_WR;
          end else begin
            w_rd_start  = 1'b1;
            w_state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RD_DONE;
        end
      end
      ST_RD_DONE: begin
        w_rdy_nxt   = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_WR: begin
        w_wr_fire   = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!request) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // All outputs are registered, so each pulse lands one edge after the state
  // that requests it; the read strobe is issued on the edge that enters RD_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr           <= '0;
      r_wdata          <= '0;
      r_cnt            <= '0;
      r_memory_in      <= '0;
      r_memory_ready   <= 1'b0;
      r_write_complete <= 1'b0;
      r_halted         <= 1'b0;
      r_sram_en        <= 1'b0;
      r_sram_we        <= 1'b0;
      r_sram_addr      <= '0;
      r_sram_wdata     <= '0;
    end else begin
      r_sram_en        <= w_rd_start | w_wr_fire;
      r_sram_we        <= w_wr_fire;
      r_memory_ready   <= w_rdy_nxt;
      r_write_complete <= w_wr_fire;
      if (w_latch) begin
        r_addr  <= request_address;
        r_wdata <= data_out;
      end
      if (w_rd_start) begin
        r_sram_addr <= request_address;
        r_cnt       <= CNT_W'(READ_LAT);
      end else if (r_state == ST_RD_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_wr_fire) begin
        r_sram_addr  <= r_addr;
        r_sram_wdata <= r_wdata;
      end
      if (w_capture) begin
        r_memory_in <= sram_rdata;
      end
      if (w_rdy_nxt && r_addr == HALT_ADDR) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign memory_in       = r_memory_in;
  assign memory_ready    = r_memory_ready;
  assign write_complete  = r_write_complete;
  assign memory_critical = (r_state != ST_IDLE);
  assign halted          = r_halted;
  assign sram_en         = r_sram_en;
  assign sram_we         = r_sram_we;
  assign sram_addr       = r_sram_addr;
  assign sram_wdata      = r_sram_wdata;
  assign dbg_state       = r_state;

endmodule
